frame_rx: RTL and testbench

Receive-side framer for the 512-bit tagged beat stream (`data_in` / `sid_in` / `data_valid`) driven into `top`.
- Groups `N_CYCLES` consecutive same-SID beats into a frame and forwards every beat one cycle later on a registered output port.
- Computes a per-frame XOR checksum and flags SID-change and inter-beat-timeout errors.
- Sits directly behind the stream input and feeds downstream consumers and the bench scoreboard.

---
 rtl/frame_rx.sv | 168 ++++++++++++++++
 tb/tb_frame_rx.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_rx.sv
// frame_rx: receive-side framer for a tagged beat stream.
// Groups N_CYCLES consecutive same-SID beats into a frame and computes an XOR
// checksum per frame. SID changes and mid-frame idle timeouts abort the frame.
// Every accepted beat is forwarded one cycle later on the data_out port.
module frame_rx #(
    parameter int DATA_WIDTH = 512,
    parameter int N_CYCLES   = 4,
    parameter int SID_WIDTH  = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [SID_WIDTH-1:0]  sid_in,
    input  logic                  data_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid,
    output logic [SID_WIDTH-1:0]  out_sid,
    output logic                  frame_last,
    output logic                  frame_done,
    output logic [SID_WIDTH-1:0]  frame_sid,
    output logic [DATA_WIDTH-1:0] frame_csum,
    output logic [31:0]           frame_count,
    output logic                  err_sid,
    output logic                  err_timeout
);

    localparam int CNT_W  = ($clog2(N_CYCLES + 1) > 1) ? $clog2(N_CYCLES + 1) : 1;
    localparam int IDLE_W = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(N_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t                state, state_n;
    logic [SID_WIDTH-1:0]  cur_sid, cur_sid_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [DATA_WIDTH-1:0] acc, acc_n;
    logic [IDLE_W-1:0]     idle_cnt, idle_n;

    logic                  start;
    logic                  complete;
    logic                  abort_sid;
    logic                  abort_to;
    logic [DATA_WIDTH-1:0] done_csum;
    logic [SID_WIDTH-1:0]  done_sid;

    // Frame state machine: decides what this cycle's beat (or idle) does to the frame
    always_comb begin
        state_n   = state;
        cur_sid_n = cur_sid;
        cnt_n     = cnt;
        acc_n     = acc;
        idle_n    = idle_cnt;
        start     = 1'b0;
        complete  = 1'b0;
        abort_sid = 1'b0;
        abort_to  = 1'b0;
        done_csum = acc;
        done_sid  = cur_sid;

        case (state)
            IDLE: begin
                if (data_valid) begin
                    start = 1'b1;
                end
            end
            COLLECT: begin
                if (data_valid) begin
                    if (sid_in == cur_sid) begin
                        acc_n  = acc ^ data_in;
                        cnt_n  = cnt + CNT_ONE;
                        idle_n = '0;
                        if (cnt_n == CNT_FULL) begin
                            complete  = 1'b1;
                            done_csum = acc_n;
                            done_sid  = cur_sid;
                            state_n   = IDLE;
                        end
                    end else begin
                        abort_sid = 1'b1;
                        start     = 1'b1;
                    end
                end else begin
                    idle_n = idle_cnt + IDLE_ONE;
                    if ((TIMEOUT != 0) && (idle_n == IDLE_LIMIT)) begin
                        abort_to = 1'b1;
                        state_n  = IDLE;
                        cnt_n    = '0;
                        idle_n   = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A beat that opens a frame is handled the same from IDLE or after an SID abort
        if (start) begin
            cur_sid_n = sid_in;
            acc_n     = data_in;
            cnt_n     = CNT_ONE;
            idle_n    = '0;
            if (N_CYCLES == 1) begin
                complete  = 1'b1;
                done_csum = data_in;
                done_sid  = sid_in;
                state_n   = IDLE;
            end else begin
                state_n = COLLECT;
            end
        end
    end

    // State and frame-tracking registers; reset discards any partial frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur_sid  <= '0;
            cnt      <= '0;
            acc      <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_n;
            cur_sid  <= cur_sid_n;
            cnt      <= cnt_n;
            acc      <= acc_n;
            idle_cnt <= idle_n;
        end
    end

    // Registered outputs: beat pass-through, completion results and error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out    <= '0;
            out_valid   <= 1'b0;
            out_sid     <= '0;
            frame_last  <= 1'b0;
            frame_done  <= 1'b0;
            frame_sid   <= '0;
            frame_csum  <= '0;
            frame_count <= '0;
            err_sid     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            out_valid   <= data_valid;
            frame_last  <= complete;
            frame_done  <= complete;
            err_sid     <= abort_sid;
            err_timeout <= abort_to;
            if (data_valid) begin
                data_out <= data_in;
                out_sid  <= sid_in;
            end
            if (complete) begin
                frame_csum  <= done_csum;
                frame_sid   <= done_sid;
                frame_count <= frame_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_frame_rx.sv
// tb_frame_rx: directed self-checking bench for frame_rx.
// Each driven beat pushes its expected output record onto a scoreboard queue;
// the record is popped and compared when out_valid appears one cycle later.
module tb_frame_rx;

    logic         clk;
    logic         rst_n;
    logic [511:0] data_in;
    logic [7:0]   sid_in;
    logic         data_valid;
    logic [511:0] data_out;
    logic         out_valid;
    logic [7:0]   out_sid;
    logic         frame_last;
    logic         frame_done;
    logic [7:0]   frame_sid;
    logic [511:0] frame_csum;
    logic [31:0]  frame_count;
    logic         err_sid;
    logic         err_timeout;

    typedef struct {
        logic [511:0] data;
        logic [7:0]   sid;
        logic         done;
        logic         esid;
        logic [511:0] csum;
        logic [7:0]   fsid;
        logic [31:0]  count;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;

    int exp_csum  = 0;
    int exp_fsid  = 0;
    int exp_count = 0;

    frame_rx #(
        .DATA_WIDTH(512),
        .N_CYCLES  (4),
        .SID_WIDTH (8),
        .TIMEOUT   (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .sid_in     (sid_in),
        .data_valid (data_valid),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_sid    (out_sid),
        .frame_last (frame_last),
        .frame_done (frame_done),
        .frame_sid  (frame_sid),
        .frame_csum (frame_csum),
        .frame_count(frame_count),
        .err_sid    (err_sid),
        .err_timeout(err_timeout)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Compares the DUT outputs for the cycle just clocked against the scoreboard
    task automatic checkOutput(input int exp_to);
        exp_t e;
        logic has_exp;
        has_exp = (sb.size() != 0);
        chk("out_valid", 512'(out_valid), 512'(has_exp));
        chk("err_timeout", 512'(err_timeout), 512'(exp_to != 0));
        if (has_exp) begin
            e = sb.pop_front();
            chk("data_out", data_out, e.data);
            chk("out_sid", 512'(out_sid), 512'(e.sid));
            chk("frame_last", 512'(frame_last), 512'(e.done));
            chk("frame_done", 512'(frame_done), 512'(e.done));
            chk("err_sid", 512'(err_sid), 512'(e.esid));
            chk("frame_csum", frame_csum, e.csum);
            chk("frame_sid", 512'(frame_sid), 512'(e.fsid));
            chk("frame_count", 512'(frame_count), 512'(e.count));
        end else begin
            chk("idle_frame_done", 512'(frame_done), 512'(0));
            chk("idle_err_sid", 512'(err_sid), 512'(0));
            chk("idle_frame_csum", frame_csum, 512'(unsigned'(exp_csum)));
            chk("idle_frame_count", 512'(frame_count), 512'(unsigned'(exp_count)));
        end
    endtask

    // Drives one cycle (beat or idle), records the expectation, then checks after the edge
    task automatic applyStimulus(input int valid, input int d, input int s,
                                 input int done, input int esid, input int exp_to);
        exp_t e;
        data_valid = (valid != 0);
        data_in    = 512'(unsigned'(d));
        sid_in     = 8'(s);
        if (valid != 0) begin
            e.data  = 512'(unsigned'(d));
            e.sid   = 8'(s);
            e.done  = (done != 0);
            e.esid  = (esid != 0);
            e.csum  = 512'(unsigned'(exp_csum));
            e.fsid  = 8'(exp_fsid);
            e.count = 32'(exp_count);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        checkOutput(exp_to);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    task automatic checkReset();
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_data_out", data_out, 512'(0));
        chk("rst_out_sid", 512'(out_sid), 512'(0));
        chk("rst_frame_last", 512'(frame_last), 512'(0));
        chk("rst_frame_done", 512'(frame_done), 512'(0));
        chk("rst_frame_sid", 512'(frame_sid), 512'(0));
        chk("rst_frame_csum", frame_csum, 512'(0));
        chk("rst_frame_count", 512'(frame_count), 512'(0));
        chk("rst_err_sid", 512'(err_sid), 512'(0));
        chk("rst_err_timeout", 512'(err_timeout), 512'(0));
    endtask

    // Directed test sequence
    initial begin
        rst_n      = 1'b0;
        data_in    = '0;
        sid_in     = '0;
        data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkReset();
        rst_n = 1'b1;
        idleCycles(2);

        $display("[TB] contiguous frame");
        applyStimulus(1, 'h1, 3, 0, 0, 0);
        applyStimulus(1, 'h2, 3, 0, 0, 0);
        applyStimulus(1, 'h4, 3, 0, 0, 0);
        exp_csum = 'hF; exp_fsid = 3; exp_count = 1;
        applyStimulus(1, 'h8, 3, 1, 0, 0);
        idleCycles(1);

        $display("[TB] gapped frame");
        exp_csum = 'hF; exp_fsid = 3; exp_count = 1;
        applyStimulus(1, 'h1, 3, 0, 0, 0);
        idleCycles(2);
        applyStimulus(1, 'h2, 3, 0, 0, 0);
        idleCycles(2);
        applyStimulus(1, 'h4, 3, 0, 0, 0);
        idleCycles(2);
        exp_count = 2;
        applyStimulus(1, 'h8, 3, 1, 0, 0);
        idleCycles(1);

        $display("[TB] sid change");
        applyStimulus(1, 'h01, 3, 0, 0, 0);
        applyStimulus(1, 'h02, 3, 0, 0, 0);
        applyStimulus(1, 'h10, 5, 0, 1, 0);
        applyStimulus(1, 'h20, 5, 0, 0, 0);
        applyStimulus(1, 'h40, 5, 0, 0, 0);
        exp_csum = 'hF0; exp_fsid = 5; exp_count = 3;
        applyStimulus(1, 'h80, 5, 1, 0, 0);
        idleCycles(1);

        $display("[TB] timeout");
        applyStimulus(1, 'h100, 1, 0, 0, 0);
        applyStimulus(1, 'h200, 1, 0, 0, 0);
        idleCycles(15);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 'h1, 9, 0, 0, 0);
        applyStimulus(1, 'h3, 9, 0, 0, 0);
        applyStimulus(1, 'h7, 9, 0, 0, 0);
        exp_csum = 'hA; exp_fsid = 9; exp_count = 4;
        applyStimulus(1, 'hF, 9, 1, 0, 0);
        idleCycles(1);

        $display("[TB] reset mid-frame");
        applyStimulus(1, 'h5, 6, 0, 0, 0);
        applyStimulus(1, 'h6, 6, 0, 0, 0);
        rst_n      = 1'b0;
        data_valid = 1'b0;
        #1;
        checkReset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_csum = 0; exp_fsid = 0; exp_count = 0;
        idleCycles(1);
        applyStimulus(1, 'h11, 7, 0, 0, 0);
        applyStimulus(1, 'h22, 7, 0, 0, 0);
        applyStimulus(1, 'h44, 7, 0, 0, 0);
        exp_csum = 'hFF; exp_fsid = 7; exp_count = 1;
        applyStimulus(1, 'h88, 7, 1, 0, 0);
        idleCycles(1);

        $display("[TB] back-to-back");
        applyStimulus(1, 'h1, 2, 0, 0, 0);
        applyStimulus(1, 'h2, 2, 0, 0, 0);
        applyStimulus(1, 'h3, 2, 0, 0, 0);
        exp_csum = 'h4; exp_fsid = 2; exp_count = 2;
        applyStimulus(1, 'h4, 2, 1, 0, 0);
        applyStimulus(1, 'h5, 2, 0, 0, 0);
        applyStimulus(1, 'h6, 2, 0, 0, 0);
        applyStimulus(1, 'h7, 2, 0, 0, 0);
        exp_csum = 'hC; exp_count = 3;
        applyStimulus(1, 'h8, 2, 1, 0, 0);
        idleCycles(2);

        chk("scoreboard_empty", 512'(sb.size()), 512'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
